ocp_wait_memory: RTL and testbench
==================================

Name: ocp_wait_memory

Overview:
Parametrised behavioural OCP slave RAM for simulation benches, replacing the fixed 32-bit single-cycle memory model.
- Generalised data width, word count and base address.
- Programmable response latency, so cores are exercised against slow slaves.
- ERR response for out-of-range and unsupported accesses.
- Back-to-back command acceptance when latency is zero.
- Sits on the core's OCP instruction or data port in testbench tops.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, power of 2, 8..128
ADDR_WIDTH, 32, byte address width
MEMWORDS, 1048576, memory size in DATA_WIDTH words
BASE_ADDR, 0, byte address mapped to word 0
WAIT_CYCLES, 0, extra cycles between accept and response, 0..15

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
i_MAddr  in  ADDR_WIDTH  byte address
i_MCmd  in  3  OCP command (`OCP_CMD_IDLE/WRITE/READ, others unsupported)
i_MData  in  DATA_WIDTH  write data
i_MByteEn  in  DATA_WIDTH/8  byte enables, bit k covers data[8k+7:8k]
o_SCmdAccept  out  1  command accepted this cycle
o_SData  out  DATA_WIDTH  read data
o_SResp  out  2  `OCP_RESP_NULL / `OCP_RESP_DVA / `OCP_RESP_ERR

Behaviour:
- Reset and clocking: reset nrst, asynchronous, active-low; clock clk.
- Reset values: state IDLE, o_SResp = NULL, o_SData = 0, wait counter 0. Memory contents are not reset.
- Initialisation: memory is zero-filled at time 0. If MEMORY_IMAGE is defined, it is then loaded with $readmemh.
- FSM states: IDLE, WAIT, RESP (one-hot).
- o_SCmdAccept = 1 when state is IDLE or RESP, or when i_MCmd == IDLE. It is 0 in WAIT with a pending command; the master must hold the command stable.
- Accept: a non-IDLE i_MCmd with state IDLE/RESP is accepted at that posedge. Address, command, data and byte enables are latched. The counter is loaded with WAIT_CYCLES.
- State transitions on accept: to WAIT if WAIT_CYCLES > 0, else to RESP.
- WAIT: counter decrements each cycle; state goes to RESP when the counter reaches 1.
- RESP: o_SResp is driven for exactly one cycle. Next state is WAIT or RESP if a new command is accepted in this cycle, else IDLE.
- Latency: a command accepted at edge N gives its response during the cycle after edge N+1+WAIT_CYCLES. With WAIT_CYCLES = 0, one command per cycle is sustained.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored (no alignment error).
- In range: addr >= BASE_ADDR and index < MEMWORDS.
- WRITE in range: memory is updated on the edge entering RESP, per enabled byte only; response DVA. Byte enables of all zero still give DVA with no change.
- READ in range: o_SData = mem[index], registered on entry to RESP; response DVA.
- Out-of-range access: response ERR. No write occurs. Read data = 32'hDEADDEAD replicated/truncated to DATA_WIDTH.
- Unsupported command codes (not IDLE/READ/WRITE): accepted, response ERR, no memory effect, o_SData unchanged.
- o_SData holds its value between read responses. o_SResp is NULL in every cycle other than a RESP cycle.
- Reset mid-operation: the pending command is discarded with no write, outputs return to reset values, and state goes to IDLE.

Optional Feature:
Macro: OCP_WAIT_MEMORY_RANDOM_WAIT_EN.
- Defined:
  - 8-bit LFSR, reset value 8'hA5, polynomial x^8+x^6+x^5+x^4+1.
  - Advances once per accepted command.
  - Wait count loaded = WAIT_CYCLES + lfsr[1:0], giving 0..3 extra cycles. A zero total goes straight to RESP.
- Undefined: no LFSR; latency is fixed at WAIT_CYCLES.

Test Plan:
- WAIT_CYCLES=0: WRITE addr 0x10, data 0x11223344, ben 4'hF, then READ 0x10 back-to-back -> o_SCmdAccept held 1; DVA at cycles N+1 and N+2; o_SData = 0x11223344.
- WAIT_CYCLES=3: READ 0x0 -> o_SCmdAccept=0 for 3 cycles while a second READ is held; first DVA 4 cycles after accept; second command then accepted.
- Partial write: write 0xAABBCCDD to 0x20, then 0x00000099 with ben 4'b0001, then read -> 0xAABBCC99.
- MEMWORDS=16, BASE_ADDR=0x1000: READ 0x0FFC and READ 0x1040 -> ERR with o_SData = 0xDEADDEAD; WRITE 0x1040 -> ERR, memory unchanged.
- DATA_WIDTH=64: WRITE 0x8 with ben 8'hF0, data 0x0123456789ABCDEF over zero memory -> readback 0x0123456700000000.
- WAIT_CYCLES=5: assert nrst low two cycles after accepting a WRITE -> no DVA, memory unchanged, o_SResp=NULL, o_SCmdAccept=1 after release.

Source files
------------

// File: rtl/ocp_wait_memory.sv
// ocp_wait_memory: parametrised OCP slave RAM model for simulation benches.
// Byte-addressed window starting at BASE_ADDR, MEMWORDS words of DATA_WIDTH.
// Each command is answered WAIT_CYCLES+1 cycles after the accept edge.
// Out-of-range or unsupported commands answer ERR.
// Optional macro OCP_WAIT_MEMORY_RANDOM_WAIT_EN adds 0..3 pseudo-random
// wait cycles per command from an 8-bit LFSR.

`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA  2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR  2'b11
`endif

module ocp_wait_memory #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    MEMWORDS    = 1048576,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [ADDR_WIDTH-1:0]   i_MAddr,
   input  logic [2:0]              i_MCmd,
   input  logic [DATA_WIDTH-1:0]   i_MData,
   input  logic [DATA_WIDTH/8-1:0] i_MByteEn,
   output logic                    o_SCmdAccept,
   output logic [DATA_WIDTH-1:0]   o_SData,
   output logic [1:0]              o_SResp
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(BE_W);
   localparam int IDX_W = (MEMWORDS > 1) ? $clog2(MEMWORDS) : 1;
   localparam logic [ADDR_WIDTH:0]   MEMWORDS_A = (ADDR_WIDTH+1)'(MEMWORDS);
   localparam logic [127:0]          DEAD_128   = {4{32'hDEADDEAD}};
   localparam logic [DATA_WIDTH-1:0] DEAD_W     = DEAD_128[DATA_WIDTH-1:0];
   localparam logic [4:0]            WAIT_L     = 5'(WAIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_WAIT = 3'b010,
      S_RESP = 3'b100
   } state_t;

   // What o_SData does when the response goes out
   typedef enum logic [1:0] {
      D_KEEP = 2'd0,
      D_MEM  = 2'd1,
      D_DEAD = 2'd2
   } dsel_t;

   logic [DATA_WIDTH-1:0] mem [0:MEMWORDS-1];

   state_t                state_reg, state_next;
   logic [4:0]            cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [2:0]            cmd_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [BE_W-1:0]       ben_reg;
   logic [1:0]            resp_reg;
   dsel_t                 dsel_reg;
   logic [DATA_WIDTH-1:0] rd_word_reg;

   logic                  accept;
   logic [ADDR_WIDTH-1:0] e_addr, off, word_off;
   logic [2:0]            e_cmd;
   logic [DATA_WIDTH-1:0] e_data;
   logic [BE_W-1:0]       e_ben;
   logic                  in_range, is_rd, is_wr, enter_resp, mem_we;
   logic [IDX_W-1:0]      idx;
   logic [4:0]            load_cnt;
   logic [BE_W-1:0]       byte_we;

`ifdef OCP_WAIT_MEMORY_RANDOM_WAIT_EN
   logic [7:0] lfsr_reg;

   // x^8+x^6+x^5+x^4+1, stepped once per accepted command
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         lfsr_reg <= 8'hA5;
      else if (accept)
         lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
   end

   assign load_cnt = WAIT_L + {3'b000, lfsr_reg[1:0]};
`else
   assign load_cnt = WAIT_L;
`endif

   // Zero fill at time 0
   initial begin
      for (int w = 0; w < MEMWORDS; w++)
         mem[w] = '0;
   end

   // Only WAIT with a real command pending stalls the master
   assign o_SCmdAccept = (state_reg != S_WAIT) || (i_MCmd == `OCP_CMD_IDLE);
   assign accept       = (state_reg != S_WAIT) && (i_MCmd != `OCP_CMD_IDLE);

   // With zero wait the command is executed on its own accept edge,
   // so the live bus is used instead of the (not yet written) latches.
   assign e_addr   = accept ? i_MAddr   : addr_reg;
   assign e_cmd    = accept ? i_MCmd    : cmd_reg;
   assign e_data   = accept ? i_MData   : data_reg;
   assign e_ben    = accept ? i_MByteEn : ben_reg;
   assign off      = e_addr - BASE_ADDR;
   assign word_off = off >> SHIFT;
   assign idx      = word_off[IDX_W-1:0];
   assign in_range = (e_addr >= BASE_ADDR) && ({1'b0, word_off} < MEMWORDS_A);
   assign is_rd    = (e_cmd == `OCP_CMD_READ);
   assign is_wr    = (e_cmd == `OCP_CMD_WRITE);

   // Next state and wait counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (accept) begin
         cnt_next   = load_cnt;
         state_next = (load_cnt == 5'd0) ? S_RESP : S_WAIT;
      end else begin
         case (state_reg)
            S_WAIT: begin
               if (cnt_reg <= 5'd1) begin
                  state_next = S_RESP;
                  cnt_next   = 5'd0;
               end else begin
                  cnt_next = cnt_reg - 5'd1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign enter_resp = (state_next == S_RESP);
   // nrst gate keeps a command on the bus during reset from writing
   assign mem_we     = enter_resp && is_wr && in_range && nrst;

   for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte_we
      assign byte_we[gi] = mem_we & e_ben[gi];
   end

   // Byte-enabled write and registered read on the edge entering RESP
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++)
         if (byte_we[b])
            mem[idx][8*b +: 8] <= e_data[8*b +: 8];
      if (enter_resp)
         rd_word_reg <= mem[idx];
   end

   // FSM, command latches and registered response outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= 5'd0;
         addr_reg  <= '0;
         cmd_reg   <= `OCP_CMD_IDLE;
         data_reg  <= '0;
         ben_reg   <= '0;
         resp_reg  <= `OCP_RESP_NULL;
         dsel_reg  <= D_KEEP;
         o_SResp   <= `OCP_RESP_NULL;
         o_SData   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            addr_reg <= i_MAddr;
            cmd_reg  <= i_MCmd;
            data_reg <= i_MData;
            ben_reg  <= i_MByteEn;
         end
         if (enter_resp) begin
            resp_reg <= (in_range && (is_rd || is_wr)) ? `OCP_RESP_DVA : `OCP_RESP_ERR;
            dsel_reg <= !is_rd ? D_KEEP : (in_range ? D_MEM : D_DEAD);
         end
         if (state_reg == S_RESP) begin
            o_SResp <= resp_reg;
            case (dsel_reg)
               D_MEM:   o_SData <= rd_word_reg;
               D_DEAD:  o_SData <= DEAD_W;
               default: o_SData <= o_SData;
            endcase
         end else begin
            o_SResp <= `OCP_RESP_NULL;
         end
      end
   end

endmodule

// File: tb/tb_ocp_wait_memory.sv
// Bench for ocp_wait_memory: five instances with different parameter sets,
// directed commands, expected responses queued per instance and checked by
// an independent response monitor (value, data and response cycle).

`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA  2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR  2'b11
`endif

module tb_ocp_wait_memory;

   localparam logic [2:0] WR  = `OCP_CMD_WRITE;
   localparam logic [2:0] RD  = `OCP_CMD_READ;
   localparam logic [1:0] DVA = `OCP_RESP_DVA;
   localparam logic [1:0] ERR = `OCP_RESP_ERR;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst  [5];
   logic [31:0] maddr [5];
   logic [2:0]  mcmd  [5];
   logic [63:0] mdata [5];
   logic [7:0]  mben  [5];
   logic [4:0]        acc;
   logic [4:0][63:0]  sdata;
   logic [4:0][1:0]   sresp;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int tag     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // u0: 32b wait0 | u1: 32b wait3 | u2: 16 words at 0x1000 | u3: 64b | u4: 32b wait5
   for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      localparam int          DW = (gi == 3) ? 64 : 32;
      localparam int          MW = (gi == 2) ? 16 : 256;
      localparam logic [31:0] BA = (gi == 2) ? 32'h1000 : 32'h0;
      localparam int          WC = (gi == 1) ? 3 : ((gi == 4) ? 5 : 0);
      logic [DW-1:0] sd_w;
      ocp_wait_memory #(
         .DATA_WIDTH (DW),
         .ADDR_WIDTH (32),
         .MEMWORDS   (MW),
         .BASE_ADDR  (BA),
         .WAIT_CYCLES(WC)
      ) u_dut (
         .clk         (clk),
         .nrst        (nrst[gi]),
         .i_MAddr     (maddr[gi]),
         .i_MCmd      (mcmd[gi]),
         .i_MData     (mdata[gi][DW-1:0]),
         .i_MByteEn   (mben[gi][DW/8-1:0]),
         .o_SCmdAccept(acc[gi]),
         .o_SData     (sd_w),
         .o_SResp     (sresp[gi])
      );
      assign sdata[gi] = 64'(sd_w);
   end

   typedef struct packed {
      logic [1:0]  resp;
      logic [63:0] data;
      logic        chk;
      logic [31:0] ecyc;
      logic [15:0] id;
   } exp_t;

   exp_t sb [5][$];
   exp_t mon_e;

   function automatic int wc_of(int u);
      return (u == 1) ? 3 : ((u == 4) ? 5 : 0);
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endtask

   // Called at a negedge; holds the command until accepted, then idles the bus
   task automatic issue(int u, logic [2:0] cmd, logic [31:0] addr, logic [63:0] data,
                        logic [7:0] ben, logic [1:0] er, logic [63:0] ed, logic chk,
                        int es, bit push);
      int   stalls = 0;
      exp_t e;
      maddr[u] = addr;
      mcmd[u]  = cmd;
      mdata[u] = data;
      mben[u]  = ben;
      #1;
      while (acc[u] !== 1'b1) begin
         if (stalls >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout u%0d txn %0d: got no accept want accept", u, tag);
            mcmd[u] = `OCP_CMD_IDLE;
            tag++;
            return;
         end
         @(negedge clk);
         #1;
         stalls++;
      end
      if (es >= 0)
         check($sformatf("stalls u%0d txn %0d", u, tag), 64'(stalls), 64'(es));
      if (push) begin
         e.resp = er;
         e.data = ed;
         e.chk  = chk;
         e.ecyc = 32'(cyc + 2 + wc_of(u));
         e.id   = 16'(tag);
         sb[u].push_back(e);
      end
      tag++;
      @(posedge clk);
      @(negedge clk);
      mcmd[u] = `OCP_CMD_IDLE;
   endtask

   // Response monitor: every non-NULL response must match the queue head
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (sresp[i] != `OCP_RESP_NULL) begin
            if (sb[i].size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_resp u%0d: got %h want none", i, sresp[i]);
            end else begin
               mon_e = sb[i].pop_front();
               $display("[TB] u%0d txn %0d resp=%0d data=%h cyc=%0d", i, mon_e.id, sresp[i], sdata[i], cyc);
               check($sformatf("resp u%0d txn %0d", i, mon_e.id), 64'(sresp[i]), 64'(mon_e.resp));
               check($sformatf("latency u%0d txn %0d", i, mon_e.id), 64'(cyc), 64'(mon_e.ecyc));
               if (mon_e.chk)
                  check($sformatf("data u%0d txn %0d", i, mon_e.id), sdata[i], mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 5; i++) begin
         nrst[i]  = 1'b0;
         mcmd[i]  = `OCP_CMD_IDLE;
         maddr[i] = '0;
         mdata[i] = '0;
         mben[i]  = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset_resp u%0d", i), 64'(sresp[i]), 64'(`OCP_RESP_NULL));
         check($sformatf("reset_data u%0d", i), sdata[i], 64'h0);
         check($sformatf("reset_accept u%0d", i), 64'(acc[i]), 64'h1);
      end
      for (int i = 0; i < 5; i++) nrst[i] = 1'b1;
      @(negedge clk);

      // u0: back-to-back write/read, partial and empty byte enables, bad commands
      issue(0, WR, 32'h10, 64'h11223344, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(0, RD, 32'h10, 64'h0, 8'hF, DVA, 64'h11223344, 1'b1, 0, 1'b1);
      issue(0, WR, 32'h20, 64'hAABBCCDD, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(0, WR, 32'h20, 64'h00000099, 8'h1, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(0, RD, 32'h20, 64'h0, 8'hF, DVA, 64'hAABBCC99, 1'b1, 0, 1'b1);
      issue(0, WR, 32'h20, 64'hFFFFFFFF, 8'h0, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(0, RD, 32'h20, 64'h0, 8'hF, DVA, 64'hAABBCC99, 1'b1, 0, 1'b1);
      issue(0, 3'b011, 32'h20, 64'h0, 8'hF, ERR, 64'hAABBCC99, 1'b1, 0, 1'b1);
      issue(0, 3'b100, 32'h20, 64'h0, 8'hF, ERR, 64'hAABBCC99, 1'b1, 0, 1'b1);

      // u1: three wait cycles, second command stalls while the first is in flight
      issue(1, WR, 32'h0, 64'h13579BDF, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(1, WR, 32'h4, 64'h2468ACE0, 8'hF, DVA, 64'h0, 1'b0, 3, 1'b1);
      repeat (8) @(negedge clk);
      issue(1, RD, 32'h0, 64'h0, 8'hF, DVA, 64'h13579BDF, 1'b1, 0, 1'b1);
      issue(1, RD, 32'h4, 64'h0, 8'hF, DVA, 64'h2468ACE0, 1'b1, 3, 1'b1);

      // u2: window 0x1000..0x103F, edges of the range
      issue(2, WR, 32'h1000, 64'h11111111, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(2, WR, 32'h103C, 64'h5A5A5A5A, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(2, RD, 32'h103C, 64'h0, 8'hF, DVA, 64'h5A5A5A5A, 1'b1, 0, 1'b1);
      issue(2, RD, 32'h0FFC, 64'h0, 8'hF, ERR, 64'hDEADDEAD, 1'b1, 0, 1'b1);
      issue(2, RD, 32'h1040, 64'h0, 8'hF, ERR, 64'hDEADDEAD, 1'b1, 0, 1'b1);
      issue(2, WR, 32'h1040, 64'h77777777, 8'hF, ERR, 64'hDEADDEAD, 1'b1, 0, 1'b1);
      issue(2, RD, 32'h1000, 64'h0, 8'hF, DVA, 64'h11111111, 1'b1, 0, 1'b1);

      // u3: 64-bit bus, upper-half byte enables, unaligned address in same word
      issue(3, WR, 32'h8, 64'h0, 8'hFF, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(3, WR, 32'h8, 64'h0123456789ABCDEF, 8'hF0, DVA, 64'h0, 1'b0, 0, 1'b1);
      issue(3, RD, 32'h8, 64'h0, 8'hFF, DVA, 64'h0123456700000000, 1'b1, 0, 1'b1);
      issue(3, RD, 32'hC, 64'h0, 8'hFF, DVA, 64'h0123456700000000, 1'b1, 0, 1'b1);

      // u4: reset while a write is waiting discards it
      issue(4, WR, 32'h40, 64'h12345678, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b1);
      repeat (8) @(negedge clk);
      issue(4, WR, 32'h40, 64'hCAFEF00D, 8'hF, DVA, 64'h0, 1'b0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      nrst[4] = 1'b0;
      repeat (2) @(negedge clk);
      nrst[4] = 1'b1;
      #1;
      check("post_reset_resp u4", 64'(sresp[4]), 64'(`OCP_RESP_NULL));
      check("post_reset_data u4", sdata[4], 64'h0);
      issue(4, RD, 32'h40, 64'h0, 8'hF, DVA, 64'h12345678, 1'b1, 0, 1'b1);

      // Let stray responses surface, then drain with a bound
      repeat (10) @(negedge clk);
      for (int k = 0; k < 100; k++) begin
         if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() == 0)
            break;
         @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         if (sb[i].size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_resp u%0d: got %0d outstanding want 0", i, sb[i].size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
